// File: rtl/demux_4_1_word_assembler.sv
// demux_4_1_word_assembler
// Receive side of the narrow-slice 4:1 link. SLICE_W-bit slices are collected
// LSB-first into W-bit words, and each finished word is written into one of
// four registered output channels. Each channel has its own valid/ready pair.
//
// Optional build macro DEMUX_SEL_CHECK_EN:
//   - adds the err output;
//   - a slice in the middle of a word whose channel select differs from the
//     word's select drops the partial word, restarts with that slice, and
//     pulses err for one cycle.
// If the macro is not defined, in_sel is sampled only on the first slice of a word.
//
// Handshake rules (both sides):
//   - A beat transfers at a rising edge where valid && ready.
//   - Input side: in_ready depends on out_ready and on internal state, never on in_valid.
//   - in_ready drops only for a final slice whose destination channel is
//     still full and not being drained in that cycle.
module demux_4_1_word_assembler #(
    parameter int W       = 4,
    parameter int SLICE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_data,
    input  logic [1:0]         in_sel,
    output logic [W-1:0]       y0,
    output logic [W-1:0]       y1,
    output logic [W-1:0]       y2,
    output logic [W-1:0]       y3,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX_SEL_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam int N     = W / SLICE_W;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int PW    = W - SLICE_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // IDLE: no slice of the current word received yet. COLLECT: some slices received.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic [PW-1:0]    partial_q, partial_d;
    logic [W-1:0]     y_q [4];
    logic [W-1:0]     y_d [4];
    logic [3:0]       out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic             accept;
    logic             sel_mismatch;
    state_e           state;

    // Debug view of the word-assembly state; slice_cnt alone determines it.
    assign state = (slice_cnt_q == '0) ? ST_IDLE : ST_COLLECT;

    // Hold off only the final slice while its destination is full and not draining.
    assign in_ready = !((slice_cnt_q == LAST) && out_valid_q[cur_sel_q] && !out_ready[cur_sel_q]);
    assign accept   = in_valid && in_ready;

`ifdef DEMUX_SEL_CHECK_EN
    assign sel_mismatch = (in_sel != cur_sel_q);
    assign err          = err_q;
`else
    assign sel_mismatch = 1'b0;
`endif

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign out_valid = out_valid_q;

    // Next state: drain consumed channels, then add the accepted slice to the word being built.
    always_comb begin
        slice_cnt_d = slice_cnt_q;
        cur_sel_d   = cur_sel_q;
        partial_d   = partial_q;
        out_valid_d = out_valid_q & ~out_ready;
        err_d       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            y_d[k] = y_q[k];
        end

        if (accept) begin
            if (state == ST_IDLE || sel_mismatch) begin
                // First slice of a word. The same path handles a restart after a select mismatch.
                err_d                  = (state == ST_COLLECT);
                cur_sel_d              = in_sel;
                partial_d[SLICE_W-1:0] = in_data;
                slice_cnt_d            = CNT_W'(1);
            end else if (slice_cnt_q == LAST) begin
                // The final slice completes the word. Writing it sets valid, which also covers a same-cycle drain.
                y_d[cur_sel_q]         = {in_data, partial_q};
                out_valid_d[cur_sel_q] = 1'b1;
                slice_cnt_d            = '0;
            end else begin
                for (int i = 0; i < N - 1; i++) begin
                    if (slice_cnt_q == CNT_W'(i)) begin
                        partial_d[i*SLICE_W +: SLICE_W] = in_data;
                    end
                end
                slice_cnt_d = slice_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers. An asynchronous reset also drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_cnt_q <= '0;
            cur_sel_q   <= '0;
            partial_q   <= '0;
            out_valid_q <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            slice_cnt_q <= slice_cnt_d;
            cur_sel_q   <= cur_sel_d;
            partial_q   <= partial_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= y_d[k];
            end
        end
    end

endmodule

// File: tb/tb_demux_4_1_word_assembler.sv
// Bench for demux_4_1_word_assembler (W=4, SLICE_W=2).
// A word-level model predicts the channel outputs, and one compare process
// checks them on every falling edge. Directed sequences also check
// hand-computed literal values.
module tb_demux_4_1_word_assembler;

  localparam int W       = 4;
  localparam int SLICE_W = 2;
  localparam int N       = W / SLICE_W;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SLICE_W-1:0] in_data;
  logic [1:0]         in_sel;
  logic [W-1:0]       y0, y1, y2, y3;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
`ifdef DEMUX_SEL_CHECK_EN
  logic               err;
`endif

  always #5 clk = ~clk;

  demux_4_1_word_assembler #(.W(W), .SLICE_W(SLICE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_SEL_CHECK_EN
    ,
    .err       (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model works at word level. It collects the slices of the current word,
  // and once all N are in it delivers the whole word to its channel.
  int         m_cnt = 0;
  logic [W-1:0] m_acc = '0;
  logic [1:0] m_sel = '0;
  logic [W-1:0] m_y [4] = '{default: '0};
  logic [3:0] m_v = '0;
  logic       m_err = 1'b0;
  logic       m_rdy;

  function automatic logic f_ready();
    return !((m_cnt == N - 1) && m_v[m_sel] && !out_ready[m_sel]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_acc = '0; m_sel = '0; m_v = '0; m_err = 1'b0;
      for (int k = 0; k < 4; k++) m_y[k] = '0;
    end else begin
      m_rdy = f_ready();
      m_err = 1'b0;
      m_v   = m_v & ~out_ready;
      if (in_valid && m_rdy) begin
        if (m_cnt == 0) begin
          m_sel = in_sel; m_acc = W'(in_data); m_cnt = 1;
        end
`ifdef DEMUX_SEL_CHECK_EN
        else if (in_sel != m_sel) begin
          m_err = 1'b1; m_sel = in_sel; m_acc = W'(in_data); m_cnt = 1;
        end
`endif
        else begin
          m_acc = m_acc | (W'(in_data) << (m_cnt * SLICE_W));
          m_cnt++;
          if (m_cnt == N) begin
            m_y[m_sel] = m_acc;
            m_v[m_sel] = 1'b1;
            m_cnt      = 0;
          end
        end
      end
    end
  end

  // ---------------- compare process (every falling edge) ----------------
  always @(negedge clk) begin
    chk("y0", 32'(y0), 32'(m_y[0]));
    chk("y1", 32'(y1), 32'(m_y[1]));
    chk("y2", 32'(y2), 32'(m_y[2]));
    chk("y3", 32'(y3), 32'(m_y[3]));
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("in_ready", 32'(in_ready), 32'(f_ready()));
`ifdef DEMUX_SEL_CHECK_EN
    chk("err", 32'(err), 32'(m_err));
`endif
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1. Holds one slice until it has been accepted. Returns at posedge+1 after the accepting edge.
  task automatic send(input logic [SLICE_W-1:0] d, input logic [1:0] s);
    logic acc;
    int   waited;
    in_valid = 1'b1; in_data = d; in_sel = s;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    tick(2);
    rst = 1'b0;
    // Values right after reset
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_y2", 32'(y2), 32'h0);

    // Basic routing: slices 10,11 to ch2 form word 4'hE
    out_ready = 4'b1111;
    send(2'b10, 2'd2);
    send(2'b11, 2'd2);
    chk("basic_y2", 32'(y2), 32'hE);
    chk("basic_valid", 32'(out_valid), 32'b0100);
    tick(1);
    chk("basic_valid_clr", 32'(out_valid), 32'h0);
    chk("basic_y0", 32'(y0), 32'h0);
    chk("basic_y1", 32'(y1), 32'h0);
    chk("basic_y3", 32'(y3), 32'h0);

    // All four channels held with out_ready low
    out_ready = 4'b0000;
    send(2'b10, 2'd0); send(2'b10, 2'd0);   // a
    send(2'b11, 2'd1); send(2'b10, 2'd1);   // b
    send(2'b00, 2'd2); send(2'b11, 2'd2);   // c
    send(2'b01, 2'd3); send(2'b11, 2'd3);   // d
    chk("all_y0", 32'(y0), 32'hA);
    chk("all_y1", 32'(y1), 32'hB);
    chk("all_y2", 32'(y2), 32'hC);
    chk("all_y3", 32'(y3), 32'hD);
    chk("all_valid", 32'(out_valid), 32'b1111);
    out_ready = 4'b1111;
    tick(1);
    out_ready = 4'b0000;
    chk("all_drained", 32'(out_valid), 32'h0);
    chk("all_hold_y1", 32'(y1), 32'hB);

    // Back-pressure on channel 1
    send(2'b01, 2'd1); send(2'b01, 2'd1);   // y1 = 5, channel full
    send(2'b10, 2'd1);                      // first slice is never stalled
    in_valid = 1'b1; in_data = 2'b01; in_sel = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(in_ready), 32'h0);
      chk("bp_stall_y1", 32'(y1), 32'h5);
    end
    @(posedge clk); #1;
    out_ready = 4'b0010;
    @(negedge clk);
    chk("bp_ready_up", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("bp_new_y1", 32'(y1), 32'h6);
    chk("bp_no_bubble", 32'(out_valid), 32'b0010);
    out_ready = 4'b1111;
    tick(1);

    // Idle gap inside a word
    send(2'b01, 2'd3);
    tick(5);
    send(2'b10, 2'd3);
    chk("gap_y3", 32'(y3), 32'h9);

    // Asynchronous reset arriving in the middle of a word
    out_ready = 4'b0000;
    send(2'b11, 2'd0);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_y3", 32'(y3), 32'h0);
    chk("arst_y1", 32'(y1), 32'h0);
    #2 rst = 1'b0;
    tick(1);
    send(2'b11, 2'd0); send(2'b01, 2'd0);
    chk("arst_y0", 32'(y0), 32'h7);
    chk("arst_v0", 32'(out_valid), 32'b0001);

`ifdef DEMUX_SEL_CHECK_EN
    // Select changes in the middle of a word
    out_ready = 4'b1111;
    tick(1);
    send(2'b11, 2'd0);
    send(2'b00, 2'd2);
    chk("sel_err_hi", 32'(err), 32'h1);
    chk("sel_no_word", 32'(out_valid), 32'h0);
    tick(1);
    chk("sel_err_lo", 32'(err), 32'h0);
    send(2'b01, 2'd2);
    chk("sel_y2", 32'(y2), 32'h4);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
